stopwatch_bench: RTL and testbench

Stopwatch peripheral for the Tamagotchi CPU subsystem. It runs a 1/100 s BCD counter (SWL) and a 1/10 s BCD counter (SWH), derived from an internal 256 Hz prescaler using a fixed 25/26-tick correction pattern. It raises 10 Hz and 1 Hz interrupt factor flags, and exposes run/reset control, counters, factors and mask on the CPU's I/O register bus at 0xF01, 0xF11, 0xF22, 0xF23 and 0xF77.

---
 rtl/stopwatch_bench_if.sv | 10 +
 rtl/stopwatch_bench.sv | 79 +++++++
 tb/tb_stopwatch_bench.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_bench_if.sv
// stopwatch_bench_if: CPU I/O register bus seen by the stopwatch peripheral.
interface stopwatch_bench_if;
  logic [11:0] bus_addr;
  logic        bus_wr;
  logic [3:0]  bus_wr_data;
  logic        bus_rd;
  logic [3:0]  bus_rd_data;
  modport master (output bus_addr, bus_wr, bus_wr_data, bus_rd, input bus_rd_data);
  modport slave (input bus_addr, bus_wr, bus_wr_data, bus_rd, output bus_rd_data);
endinterface

// File: rtl/stopwatch_bench.sv
// stopwatch_bench: 1/100 s and 1/10 s BCD stopwatch with 10 Hz / 1 Hz interrupt factors.
module stopwatch_bench #(
  parameter int CLK_PER_256HZ = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  stopwatch_bench_if.slave        bus,
  output logic                    enable_stopwatch,
  output logic [3:0]              counter_swl,
  output logic [3:0]              counter_swh,
  output logic [1:0]              stopwatch_factor,
  output logic [1:0]              stopwatch_mask,
  output logic                    interrupt_req
);
  localparam int PW = CLK_PER_256HZ > 1 ? $clog2(CLK_PER_256HZ) : 1;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_sub;
  logic [3:0]    r_swl;
  logic [3:0]    r_swh;
  logic [1:0]    r_factor;
  logic [1:0]    r_mask;
  logic          r_en;
  logic          w_tick;
  logic [1:0]    w_len;
  logic          w_step;
  logic          w_swl_wrap;
  logic          w_swh_wrap;
  logic          w_wr_run;
  logic          w_clr;
  logic          w_rd_factor;
  assign w_tick = r_en && (r_presc == PW'(CLK_PER_256HZ - 1));
  // Odd SWL digits take 2 ticks, except SWL=1 in the 26-tick pattern (SWH bit 1 clear).
  assign w_len       = (!r_swl[0] || (r_swl == 4'd1 && !r_swh[1])) ? 2'd3 : 2'd2;
  assign w_step      = w_tick && (r_sub + 2'd1 == w_len);
  assign w_swl_wrap  = w_step && r_swl == 4'd9;
  assign w_swh_wrap  = w_swl_wrap && r_swh == 4'd9;
  assign w_wr_run    = bus.bus_wr && bus.bus_addr == 12'hF77;
  assign w_clr       = w_wr_run && bus.bus_wr_data[1];
  assign w_rd_factor = bus.bus_rd && bus.bus_addr == 12'hF01;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc  <= '0;
      r_sub    <= '0;
      r_swl    <= '0;
      r_swh    <= '0;
      r_factor <= '0;
      r_mask   <= '0;
      r_en     <= 1'b0;
    end else begin
      if (w_wr_run) r_en <= bus.bus_wr_data[0];
      if (bus.bus_wr && bus.bus_addr == 12'hF11) r_mask <= bus.bus_wr_data[1:0];
      r_factor <= (w_rd_factor ? 2'b00 : r_factor) | {w_swh_wrap, w_swl_wrap};
      if (w_clr) begin
        r_presc <= '0;
        r_sub   <= '0;
        r_swl   <= '0;
        r_swh   <= '0;
      end else if (r_en) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) r_sub <= w_step ? 2'd0 : r_sub + 2'd1;
        if (w_step) r_swl <= w_swl_wrap ? 4'd0 : r_swl + 4'd1;
        if (w_swl_wrap) r_swh <= w_swh_wrap ? 4'd0 : r_swh + 4'd1;
      end
    end
  end
  always_comb begin
    bus.bus_rd_data = bus.bus_addr == 12'hF01 ? {2'b00, r_factor} :
                      bus.bus_addr == 12'hF11 ? {2'b00, r_mask} :
                      bus.bus_addr == 12'hF22 ? r_swl :
                      bus.bus_addr == 12'hF23 ? r_swh :
                      bus.bus_addr == 12'hF77 ? {3'b000, r_en} : 4'd0;
  end
  assign enable_stopwatch = r_en;
  assign counter_swl      = r_swl;
  assign counter_swh      = r_swh;
  assign stopwatch_factor = r_factor;
  assign stopwatch_mask   = r_mask;
  assign interrupt_req    = |(r_factor & r_mask);
endmodule

// File: tb/tb_stopwatch_bench.sv
// tb_stopwatch_bench: directed checks of stopwatch timing, registers and interrupts.
module tb_stopwatch_bench;
  localparam int P = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic       enable_stopwatch;
  logic [3:0] counter_swl;
  logic [3:0] counter_swh;
  logic [1:0] stopwatch_factor;
  logic [1:0] stopwatch_mask;
  logic       interrupt_req;
  int errors = 0;
  int checks = 0;
  logic [3:0] rd_val;
  stopwatch_bench_if bus ();
  stopwatch_bench #(.CLK_PER_256HZ(P)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .enable_stopwatch(enable_stopwatch),
    .counter_swl(counter_swl),
    .counter_swh(counter_swh),
    .stopwatch_factor(stopwatch_factor),
    .stopwatch_mask(stopwatch_mask),
    .interrupt_req(interrupt_req)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask
  task automatic wr(input logic [11:0] a, input logic [3:0] d);
    bus.bus_addr = a;
    bus.bus_wr_data = d;
    bus.bus_wr = 1'b1;
    cyc(1);
    bus.bus_wr = 1'b0;
  endtask
  task automatic peek(input logic [11:0] a, output logic [3:0] d);
    bus.bus_addr = a;
    #1;
    d = bus.bus_rd_data;
  endtask
  task automatic rd(input logic [11:0] a, output logic [3:0] d);
    bus.bus_addr = a;
    bus.bus_rd = 1'b1;
    #1;
    d = bus.bus_rd_data;
    @(posedge clk);
    #1;
    bus.bus_rd = 1'b0;
  endtask
  function automatic logic [7:0] cnt();
    return {counter_swh, counter_swl};
  endfunction
  initial begin
    bus.bus_addr = 12'h000;
    bus.bus_wr = 1'b0;
    bus.bus_wr_data = 4'd0;
    bus.bus_rd = 1'b0;
    do_reset();
    check("rst_cnt", cnt(), 8'h00);
    check("rst_en", {7'd0, enable_stopwatch}, 8'd0);
    check("rst_factor", {6'd0, stopwatch_factor}, 8'd0);
    check("rst_mask", {6'd0, stopwatch_mask}, 8'd0);
    check("rst_irq", {7'd0, interrupt_req}, 8'd0);
    peek(12'hF77, rd_val);
    check("rst_rd_f77", {4'd0, rd_val}, 8'd0);
    // 1 s pattern and multi-second drift
    wr(12'hF77, 4'd1);
    check("en_on", {7'd0, enable_stopwatch}, 8'd1);
    cyc(3 * P - 1);
    check("swl_before_1", cnt(), 8'h00);
    cyc(1);
    check("swl_1", cnt(), 8'h01);
    cyc(3 * P);
    check("swl_2", cnt(), 8'h02);
    cyc(3 * P);
    check("swl_3", cnt(), 8'h03);
    cyc(17 * P);
    check("swh_1", cnt(), 8'h10);
    check("factor_10hz", {6'd0, stopwatch_factor}, 8'd1);
    cyc(51 * P);
    check("swh_3", cnt(), 8'h30);
    cyc(178 * P + P - 1);
    check("last_99", cnt(), 8'h99);
    cyc(1);
    check("wrap_1s", cnt(), 8'h00);
    check("factor_1hz", {6'd0, stopwatch_factor}, 8'd3);
    cyc(512 * P - 1);
    check("last_99_3s", cnt(), 8'h99);
    cyc(1);
    check("wrap_3s", cnt(), 8'h00);
    // partial second and factor read-clear
    do_reset();
    wr(12'hF77, 4'd1);
    cyc(45 * P);
    peek(12'hF22, rd_val);
    check("rd_swl_7", {4'd0, rd_val}, 8'd7);
    peek(12'hF23, rd_val);
    check("rd_swh_1", {4'd0, rd_val}, 8'd1);
    peek(12'hF00, rd_val);
    check("rd_unmapped", {4'd0, rd_val}, 8'd0);
    peek(12'hF77, rd_val);
    check("rd_f77_run", {4'd0, rd_val}, 8'd1);
    rd(12'hF01, rd_val);
    check("rd_factor", {4'd0, rd_val}, 8'd1);
    check("factor_cleared", {6'd0, stopwatch_factor}, 8'd0);
    cyc(62 * P - 1);
    peek(12'hF23, rd_val);
    check("rd_swh_4", {4'd0, rd_val}, 8'd4);
    // pause and resume; the disabling write edge still counts one running cycle
    do_reset();
    wr(12'hF77, 4'd1);
    cyc(45 * P);
    check("pause_pre", cnt(), 8'h17);
    wr(12'hF77, 4'd0);
    cyc(45 * P);
    check("paused", cnt(), 8'h17);
    check("paused_en", {7'd0, enable_stopwatch}, 8'd0);
    wr(12'hF77, 4'd1);
    cyc(42 * P - 2);
    check("resume_33", cnt(), 8'h33);
    cyc(1);
    check("resume_34", cnt(), 8'h34);
    // reset bit together with run bit
    do_reset();
    wr(12'hF77, 4'd1);
    cyc(75 * P + 2);
    check("preload_29", cnt(), 8'h29);
    wr(12'hF77, 4'd3);
    check("clr_cnt", cnt(), 8'h00);
    check("clr_en", {7'd0, enable_stopwatch}, 8'd1);
    check("clr_keeps_factor", {6'd0, stopwatch_factor}, 8'd1);
    cyc(45 * P - 1);
    check("clr_16", cnt(), 8'h16);
    cyc(1);
    check("clr_17", cnt(), 8'h17);
    // mask=01, read of F01 coincides with the set edge
    do_reset();
    wr(12'hF11, 4'd1);
    wr(12'hF77, 4'd1);
    cyc(26 * P - 1);
    check("irq01_pre", {7'd0, interrupt_req}, 8'd0);
    rd(12'hF01, rd_val);
    check("rd_before_set", {4'd0, rd_val}, 8'd0);
    check("set_wins", {6'd0, stopwatch_factor}, 8'd1);
    check("irq01", {7'd0, interrupt_req}, 8'd1);
    wr(12'hF01, 4'd0);
    check("f01_wr_ignored", {6'd0, stopwatch_factor}, 8'd1);
    // mask=10
    do_reset();
    wr(12'hF11, 4'd2);
    wr(12'hF77, 4'd1);
    cyc(26 * P);
    check("irq10_26", {7'd0, interrupt_req}, 8'd0);
    cyc(230 * P - 1);
    check("irq10_pre", {7'd0, interrupt_req}, 8'd0);
    cyc(1);
    check("irq10", {7'd0, interrupt_req}, 8'd1);
    check("irq10_factor", {6'd0, stopwatch_factor}, 8'd3);
    // mask register width and start gating
    do_reset();
    wr(12'hF11, 4'd6);
    check("mask_10", {6'd0, stopwatch_mask}, 8'd2);
    peek(12'hF11, rd_val);
    check("rd_mask", {4'd0, rd_val}, 8'd2);
    wr(12'hF22, 4'd5);
    cyc(45 * P);
    check("gated_cnt", cnt(), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
